// File: rtl/lpc_reconstructor.sv
// LPC synthesis filter: rebuilds PCM samples from warm-up values and quantised residuals.
// Single serial MAC (one tap per cycle); oReady drops for M cycles while each prediction is formed.
module lpc_reconstructor #(
    parameter int MAX_ORDER = 12,
    parameter int COEFF_W   = 12,
    parameter int SAMPLE_W  = 16,
    parameter int ACC_W     = 32
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic                iStart,
    input  logic [3:0]          iOrder,
    input  logic [4:0]          iShift,
    input  logic [15:0]         iBlockSize,
    input  logic                iLoad,
    input  logic [COEFF_W-1:0]  iCoeff,
    input  logic                iValid,
    input  logic [SAMPLE_W-1:0] iResidual,
    output logic                oReady,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oDone
);

    typedef enum logic [2:0] {IDLE, LOAD, WARMUP, PREDICT, WAIT} state_t;

    state_t state, state_nxt;

    logic [3:0]  order, order_in, idx, tap;
    logic [4:0]  shift;
    logic [15:0] block_size, count, count_inc;

    logic signed [COEFF_W-1:0]         coeff [MAX_ORDER];
    logic signed [SAMPLE_W-1:0]        hist  [MAX_ORDER];
    logic signed [COEFF_W+SAMPLE_W-1:0] prod;
    logic signed [ACC_W-1:0]           acc, acc_sum;

    // Prediction only matters modulo 2^SAMPLE_W once added to the residual.
    logic [SAMPLE_W-1:0] pred, emit_dat;
    logic                accept, emit, done_nxt, last_tap;

    assign order_in  = (iOrder > 4'(MAX_ORDER)) ? 4'(MAX_ORDER) : iOrder;
    assign accept    = iEnable && iValid && oReady;
    assign count_inc = count + 16'd1;
    assign prod      = coeff[tap] * hist[tap];
    assign acc_sum   = acc + ACC_W'(prod);
    assign last_tap  = (tap == order - 4'd1);

    always_ff @(posedge iClock) begin
        if (iReset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_dat  = iResidual;
        done_nxt  = 1'b0;
        if (iEnable) begin
            if (iStart) begin
                if (iBlockSize == 16'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (order_in != 4'd0) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = WAIT;
                end
            end else begin
                case (state)
                    LOAD: begin
                        if (iLoad && idx == order - 4'd1) state_nxt = WARMUP;
                    end
                    WARMUP: begin
                        if (accept) begin
                            emit = 1'b1;
                            if (count_inc == block_size) begin
                                done_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end else if (count_inc == {12'd0, order}) begin
                                state_nxt = PREDICT;
                            end
                        end
                    end
                    PREDICT: begin
                        if (last_tap) state_nxt = WAIT;
                    end
                    WAIT: begin
                        if (accept) begin
                            emit     = 1'b1;
                            emit_dat = iResidual + pred;
                            if (count_inc == block_size) begin
                                done_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end else if (order != 4'd0) begin
                                state_nxt = PREDICT;
                            end
                        end
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            order      <= '0;
            shift      <= '0;
            block_size <= '0;
            count      <= '0;
            idx        <= '0;
            tap        <= '0;
            acc        <= '0;
            pred       <= '0;
            oReady     <= 1'b0;
            oSample    <= '0;
            oValid     <= 1'b0;
            oDone      <= 1'b0;
            for (int k = 0; k < MAX_ORDER; k++) begin
                coeff[k] <= '0;
                hist[k]  <= '0;
            end
        end else begin
            oValid <= 1'b0;
            oDone  <= 1'b0;
            if (iEnable) begin
                oReady <= (state_nxt == WARMUP) || (state_nxt == WAIT);
                oValid <= emit;
                oDone  <= done_nxt;
                if (emit) oSample <= emit_dat;
                if (iStart) begin
                    order      <= order_in;
                    shift      <= iShift;
                    block_size <= iBlockSize;
                    count      <= '0;
                    idx        <= '0;
                    tap        <= '0;
                    acc        <= '0;
                    pred       <= '0;
                    for (int k = 0; k < MAX_ORDER; k++) hist[k] <= '0;
                end else begin
                    if (state == LOAD && iLoad) begin
                        coeff[idx] <= iCoeff;
                        idx        <= idx + 4'd1;
                    end
                    if (emit) begin
                        hist[0] <= emit_dat;
                        for (int k = 1; k < MAX_ORDER; k++) hist[k] <= hist[k-1];
                        count <= count_inc;
                    end
                    // Accumulator is held at zero outside PREDICT so each prediction starts clean.
                    if (state == PREDICT) begin
                        acc <= acc_sum;
                        tap <= tap + 4'd1;
                        if (last_tap) pred <= SAMPLE_W'(acc_sum >>> shift);
                    end else begin
                        acc <= '0;
                        tap <= '0;
                    end
                end
            end
        end
    end

endmodule
